hamming_decode: RTL
===================

HAMMING_DECODE -- requirements
Module: hamming_decode

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating error counters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  codeword on data_in is valid.
REQ-005 in_ready  output  1  decoder can accept a codeword this cycle.
REQ-006 data_in  input  12  received Hamming(12,8) codeword.
REQ-007 out_ready  input  1  downstream accepts the output this cycle.
REQ-008 out_valid  output  1  data_out and the status outputs are valid.
REQ-009 data_out  output  8  decoded and corrected data byte.
REQ-010 syndrome  output  4  raw syndrome of the delivered codeword.
REQ-011 err_corr  output  1  single-bit error found and corrected.
REQ-012 err_uncorr  output  1  syndrome 13..15; codeword not correctable.
REQ-013 clr_counts  input  1  synchronous clear of both counters.
REQ-014 corr_count  output  CNT_W  saturating count of delivered err_corr results.
REQ-015 uncorr_count  output  CNT_W  saturating count of delivered err_uncorr results.

Function
REQ-016 Codeword format: bit index j holds position j+1; parity bits at indices 0,1,3,7 (positions 1,2,4,8); data d0..d7 at indices 2,4,5,6,8,9,10,11.
REQ-017 Parity at position 2^m covers every position with bit m set, even parity.
REQ-018 Syndrome: XOR of the positions (j+1) of all set codeword bits; 0 means no error.
REQ-019 Syndrome 1..12: invert codeword bit (syndrome-1), then extract data; err_corr=1.
REQ-020 Syndrome 13..15: no inversion; data_out = raw extracted data bits; err_uncorr=1.
REQ-021 err_corr and err_uncorr are never both 1; both are 0 when syndrome=0.
REQ-022 Two-stage pipeline: stage 1 registers the codeword and its syndrome; stage 2 registers the corrected data and flags.
REQ-023 Input handshake: transfer when in_valid && in_ready; stage 1 loads only on a transfer.
REQ-024 Output handshake: transfer when out_valid && out_ready; the output holds stable while out_valid && !out_ready.
REQ-025 Stage 2 loads when !out_valid || out_ready; out_valid then takes the stage-1 valid bit.
REQ-026 in_ready = !s1_valid || (stage 2 loads this cycle); combinational, with no path from in_valid.
REQ-027 Latency with no stall: codeword accepted at edge N is presented with out_valid=1 after edge N+1 and before edge N+2.
REQ-028 Throughput: one codeword per cycle while out_ready=1; no bubbles and no loss under back-pressure.
REQ-029 Counters increment once per output transfer whose err_corr or err_uncorr flag is set, not once per held cycle.
REQ-030 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-031 clr_counts zeroes both counters next edge; clear wins over a simultaneous increment.

Reset
REQ-032 While rst=1: in_ready=0; stage valids, out_valid, data_out, syndrome, err_corr, err_uncorr, corr_count and uncorr_count all clear to 0 at the next edge.
REQ-033 Reset mid-operation discards every in-flight codeword without delivering it; counters clear.
REQ-034 First cycle after rst deasserts: in_ready=1, out_valid=0.

Verification
REQ-035 Clean: data_in=12'hA27, out_ready=1 -> two cycles later data_out=8'hA5, syndrome=0, err_corr=0, err_uncorr=0.
REQ-036 Single error: data_in=12'hA07 (bit 5 flipped) -> data_out=8'hA5, syndrome=6, err_corr=1, corr_count increments by 1.
REQ-037 Uncorrectable: data_in=12'h226 (bits 0 and 11 flipped) -> syndrome=13, err_uncorr=1, data_out=8'h25, uncorr_count increments by 1.
REQ-038 Back-pressure:
- stimulus: back-to-back stream of 4 codewords, out_ready held 0 for 5 cycles;
- required: in_ready drops after 2 accepts, the output holds stable, and all 4 codewords are delivered in order once out_ready=1.
REQ-039 Saturation/clear:
- stimulus: CNT_W=2, 5 single-error words, then clr_counts asserted together with one further error;
- required: corr_count reaches 3 and stays 3, then reads 0 after the clear.
REQ-040 Reset mid-flight: rst asserted with both stages full -> next cycle out_valid=0, counters 0, and no stale word is delivered after release.

Source files
------------

// File: rtl/hamming_decode.sv
// Two-stage pipelined Hamming(12,8) decoder with valid/ready handshakes on both
// sides and saturating counters of delivered corrected / uncorrectable words.
module hamming_decode #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      data_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       data_out,
  output logic [3:0]       syndrome,
  output logic             err_corr,
  output logic             err_uncorr,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  logic        s1_valid_reg;
  logic [11:0] s1_code_reg;
  logic [3:0]  s1_syn_reg;
  logic [3:0]  in_syn;
  logic [11:0] fixed_code;
  logic [7:0]  fixed_data;
  logic        syn_corr;
  logic        syn_uncorr;
  logic        s2_load;
  logic        in_fire;
  logic        out_fire;

  // Syndrome is the XOR of the 1-based positions of every set codeword bit.
  always_comb begin
    in_syn = '0;
    for (int j = 0; j < 12; j++) begin
      if (data_in[j]) in_syn = in_syn ^ 4'(j + 1);
    end
  end

  // Syndromes 13..15 match no position, so those words pass through unflipped.
  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_fix
      assign fixed_code[gi] = s1_code_reg[gi] ^ (s1_syn_reg == 4'(gi + 1));
    end
  endgenerate

  assign fixed_data = {fixed_code[11:8], fixed_code[6:4], fixed_code[2]};
  assign syn_corr   = (s1_syn_reg != 4'd0) && (s1_syn_reg <= 4'd12);
  assign syn_uncorr = (s1_syn_reg >= 4'd13);

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid_reg || s2_load);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_code_reg  <= '0;
      s1_syn_reg   <= '0;
    end else if (in_fire) begin
      s1_valid_reg <= 1'b1;
      s1_code_reg  <= data_in;
      s1_syn_reg   <= in_syn;
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      syndrome   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
    end else if (s2_load) begin
      out_valid  <= s1_valid_reg;
      data_out   <= fixed_data;
      syndrome   <= s1_syn_reg;
      err_corr   <= syn_corr;
      err_uncorr <= syn_uncorr;
    end
  end

  // Counting on the output transfer keeps a stalled word from being counted twice.
  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (out_fire) begin
      if (err_corr && (corr_count != {CNT_W{1'b1}}))
        corr_count <= corr_count + 1'b1;
      if (err_uncorr && (uncorr_count != {CNT_W{1'b1}}))
        uncorr_count <= uncorr_count + 1'b1;
    end
  end

endmodule
